instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the multicycle control FSM.
- On a fetch request it issues a word read to instruction memory over a req/ready handshake.
- It latches the returned word into the instruction register (IR).
- It presents decoded fields (op_code, funct, rs, rt, rd, shamt, imm16) to the control FSM and datapath, with a one-cycle instr_valid strobe so control can leave its fetch/decode wait.

Parameters:
N, 32, data/instruction width (fixed 32 for MIPS field layout)
ADDR_W, 32, byte address width
TIMEOUT_CYCLES, 16, max wait cycles for mem_ready (used only with FETCH_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
fetch_start  in  1  request a fetch of word at pc (pulse or level; sampled in IDLE only)
pc  in  ADDR_W  byte address of instruction
mem_req  out  1  read request to instruction memory
mem_addr  out  ADDR_W  address held stable while mem_req=1
mem_ready  in  1  memory returns mem_rdata this cycle
mem_rdata  in  N  instruction word
ir  out  N  instruction register
op_code  out  6  ir[31:26]
rs  out  5  ir[25:21]
rt  out  5  ir[20:16]
rd  out  5  ir[15:11]
shamt  out  5  ir[10:6]
funct  out  6  ir[5:0]
imm16  out  16  ir[15:0]
instr_valid  out  1  one-cycle strobe: new IR contents valid
busy  out  1  high in REQUEST/WAIT
fault  out  1  sticky: misaligned pc (or timeout); cleared by next accepted fetch_start

Behaviour:
- Reset (rst=0, async): state=IDLE; mem_req=0, mem_addr=0, ir=0 (all fields 0), instr_valid=0, busy=0, fault=0. A reset asserted mid-transaction drops mem_req immediately; any late mem_ready is ignored.
- States: IDLE, REQUEST, WAIT.
- IDLE, fetch_start=1, pc[1:0]==0: latch mem_addr=pc, fault<=0, go REQUEST.
- IDLE, fetch_start=1, pc[1:0]!=0: no memory request; fault<=1, stay IDLE; ir unchanged; instr_valid stays 0.
- REQUEST: mem_req=1, busy=1.
  - mem_ready=1 in the same cycle: ir<=mem_rdata, go IDLE.
  - Otherwise go WAIT.
- WAIT: mem_req=1, mem_addr unchanged. On mem_ready=1: ir<=mem_rdata, go IDLE.
- instr_valid is registered, high exactly the cycle after ir updates, i.e. the first IDLE cycle. Minimum latency: fetch_start at cycle 0 -> mem_req at cycle 1 -> with zero-wait memory, ir/instr_valid at cycle 2.
- fetch_start while busy: ignored, not queued.
- fetch_start in the instr_valid cycle: accepted (back-to-back fetch).
- Decoded fields are combinational slices of ir; they hold until the next successful fetch.
- mem_ready while mem_req=0: ignored.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a counter clears on entry to REQUEST and increments each cycle in REQUEST/WAIT without mem_ready. When it reaches TIMEOUT_CYCLES, the fetch is aborted:
  - mem_req<=0, fault<=1, state IDLE
  - ir unchanged, no instr_valid
- mem_ready arriving on the same cycle as the terminal count wins: the fetch completes normally.
- Undefined: no counter; WAIT persists indefinitely until mem_ready.

Decomposition:
- Shared defines (alongside the existing MIPS opcode defines): IR field bit positions, fetch state encodings (IDLE=2'b00, REQUEST=2'b01, WAIT=2'b10).
- One sub-module: fetch_watchdog (counter + terminal-count compare), instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset release, zero-wait memory:
  - Stimulus: pc=0x0000_0040, fetch_start pulse, mem_ready tied 1, mem_rdata=0x0232_8020 (add $s0,$s1,$s2).
  - Response: mem_req one cycle with mem_addr=0x40; instr_valid at cycle 2; op_code=0, rs=17, rt=18, rd=16, funct=0x20.
- Wait states:
  - Stimulus: mem_ready asserted 3 cycles after mem_req.
  - Response: mem_addr stable 0x40 throughout; busy=1 for 4 cycles; single instr_valid; no extra requests.
- Misaligned pc:
  - Stimulus: pc=0x0000_0042 with fetch_start.
  - Response: mem_req never asserts; fault=1; ir keeps previous value.
  - Stimulus: then fetch_start with pc=0x44.
  - Response: fault clears.
- Busy/back-to-back:
  - Stimulus: fetch_start held high during WAIT.
  - Response: ignored.
  - Stimulus: fetch_start re-asserted in the instr_valid cycle.
  - Response: new mem_req the next cycle with the new pc.
- Reset mid-fetch:
  - Stimulus: rst=0 during WAIT, then mem_ready=1 after release.
  - Response: mem_req=0 asynchronously; ir=0; no instr_valid.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16:
  - Stimulus: mem_ready never asserted.
  - Response: mem_req drops after 16 cycles; fault=1.
  - Stimulus: mem_ready on exactly cycle 16.
  - Response: normal completion, fault=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice: MIPS opcodes, IR field
// positions, fetch state encodings and a field-decode helper.
package instr_fetch_unit_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

    typedef enum logic [1:0] {
        FS_IDLE    = 2'b00,
        FS_REQUEST = 2'b01,
        FS_WAIT    = 2'b10
    } fetch_state_t;

    typedef struct packed {
        logic [5:0]  op_code;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm16;
    } ir_fields_t;

    function automatic ir_fields_t decode_ir(input logic [INSTR_W-1:0] word);
        ir_fields_t f;
        f.op_code = word[OP_MSB:OP_LSB];
        f.rs      = word[RS_MSB:RS_LSB];
        f.rt      = word[RT_MSB:RT_LSB];
        f.rd      = word[RD_MSB:RD_LSB];
        f.shamt   = word[SHAMT_MSB:SHAMT_LSB];
        f.funct   = word[FUNCT_MSB:FUNCT_LSB];
        f.imm16   = word[IMM_MSB:IMM_LSB];
        return f;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_fetch_watchdog.sv
// Fetch watchdog: counts busy cycles without mem_ready and flags the cycle in
// which the LIMIT-th such cycle occurs. Only instantiated with FETCH_TIMEOUT_EN.
module fetch_watchdog
    import instr_fetch_unit_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    output logic expired
);

    localparam int CNT_W = $clog2(LIMIT + 1) + 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count_reg;

    // Count 0 corresponds to the REQUEST cycle, so LIMIT-1 marks the last permitted cycle.
    assign expired = active && (count_reg == TERMINAL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (start) begin
            count_reg <= '0;
        end else if (active && !expired) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: word read over a req/ready handshake into the IR,
// decoded fields and a one-cycle instr_valid strobe. Optional: FETCH_TIMEOUT_EN.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int N              = 32,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_start,
    input  logic [ADDR_W-1:0] pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [N-1:0]      mem_rdata,
    output logic [N-1:0]      ir,
    output logic [5:0]        op_code,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        shamt,
    output logic [5:0]        funct,
    output logic [15:0]       imm16,
    output logic              instr_valid,
    output logic              busy,
    output logic              fault
);

    fetch_state_t      state_reg;
    logic              mem_req_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [N-1:0]      ir_reg;
    logic              instr_valid_reg;
    logic              busy_reg;
    logic              fault_reg;

    logic       accept_fetch;
    logic       timeout_hit;
    ir_fields_t fields;

    assign accept_fetch = (state_reg == FS_IDLE) && fetch_start && (pc[1:0] == 2'b00);

`ifdef FETCH_TIMEOUT_EN
    fetch_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_fetch_watchdog (
        .clk     (clk),
        .rst     (rst),
        .start   (accept_fetch),
        .active  (busy_reg && !mem_ready),
        .expired (timeout_hit)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= FS_IDLE;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= '0;
            ir_reg          <= '0;
            instr_valid_reg <= 1'b0;
            busy_reg        <= 1'b0;
            fault_reg       <= 1'b0;
        end else begin
            instr_valid_reg <= 1'b0;
            case (state_reg)
                FS_IDLE: begin
                    if (accept_fetch) begin
                        mem_addr_reg <= pc;
                        mem_req_reg  <= 1'b1;
                        busy_reg     <= 1'b1;
                        fault_reg    <= 1'b0;
                        state_reg    <= FS_REQUEST;
                    end else if (fetch_start) begin
                        fault_reg <= 1'b1;
                    end
                end
                FS_REQUEST, FS_WAIT: begin
                    // A response on the terminal-count cycle still completes the fetch.
                    if (mem_ready) begin
                        ir_reg          <= mem_rdata;
                        instr_valid_reg <= 1'b1;
                        mem_req_reg     <= 1'b0;
                        busy_reg        <= 1'b0;
                        state_reg       <= FS_IDLE;
                    end else if (timeout_hit) begin
                        mem_req_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        fault_reg   <= 1'b1;
                        state_reg   <= FS_IDLE;
                    end else begin
                        state_reg <= FS_WAIT;
                    end
                end
                default: begin
                    mem_req_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                    state_reg   <= FS_IDLE;
                end
            endcase
        end
    end

    assign fields = decode_ir(ir_reg);

    assign mem_req     = mem_req_reg;
    assign mem_addr    = mem_addr_reg;
    assign ir          = ir_reg;
    assign instr_valid = instr_valid_reg;
    assign busy        = busy_reg;
    assign fault       = fault_reg;
    assign op_code     = fields.op_code;
    assign rs          = fields.rs;
    assign rt          = fields.rt;
    assign rd          = fields.rd;
    assign shamt       = fields.shamt;
    assign funct       = fields.funct;
    assign imm16       = fields.imm16;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetches push expected
// addresses/words; a monitor checks each request and each instr_valid strobe.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_start = 1'b0;
    logic [31:0] pc = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] ir;
    logic [5:0]  op_code;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic        instr_valid;
    logic        busy;
    logic        fault;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .N              (32),
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .pc          (pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .ir          (ir),
        .op_code     (op_code),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm16       (imm16),
        .instr_valid (instr_valid),
        .busy        (busy),
        .fault       (fault)
    );

    typedef struct {
        logic [31:0] word;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          wait_cfg = 0;
    bit          mem_stall = 1'b0;
    bit          force_ready = 1'b0;
    int          wait_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] word, input logic [5:0] op, input logic [4:0] r_s,
                            input logic [4:0] r_t, input logic [4:0] r_d, input logic [4:0] sh,
                            input logic [5:0] fn, input logic [15:0] imm);
        exp_t e;
        e.word = word; e.op = op; e.rs = r_s; e.rt = r_t; e.rd = r_d;
        e.shamt = sh; e.funct = fn; e.imm = imm;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h40:  return 32'h0232_8020;
            32'h44:  return 32'h2108_FFFC;
            32'h48:  return 32'h0009_4880;
            32'h4C:  return 32'hAC0A_0008;
            default: return {16'hDEAD, a[15:0]};
        endcase
    endfunction

    // Instruction memory: answers wait_cfg cycles after the request appears.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_req) begin
                mem_ready = !mem_stall && (wait_cnt >= wait_cfg);
                mem_rdata = mem_word(mem_addr);
                wait_cnt++;
            end else begin
                mem_ready = force_ready;
                mem_rdata = 32'hFFFF_FFFF;
                wait_cnt  = 0;
            end
        end
    end

    // Monitor: checks every new request address and every instr_valid strobe.
    initial begin
        logic        prev_req;
        logic [31:0] prev_addr;
        exp_t        e;
        prev_req  = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !prev_req) begin
                if (addr_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_req: got addr 0x%08h, want no request", mem_addr);
                end else begin
                    check("req_addr", mem_addr, addr_q.pop_front());
                end
            end
            if (mem_req && prev_req) check("addr_stable", mem_addr, prev_addr);
            if (instr_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_valid: got ir 0x%08h, want no strobe", ir);
                end else begin
                    e = exp_q.pop_front();
                    check("ir", ir, e.word);
                    check("op_code", 32'(op_code), 32'(e.op));
                    check("rs", 32'(rs), 32'(e.rs));
                    check("rt", 32'(rt), 32'(e.rt));
                    check("rd", 32'(rd), 32'(e.rd));
                    check("shamt", 32'(shamt), 32'(e.shamt));
                    check("funct", 32'(funct), 32'(e.funct));
                    check("imm16", 32'(imm16), 32'(e.imm));
                end
            end
            prev_req  = mem_req;
            prev_addr = mem_addr;
        end
    end

    task automatic do_fetch(input logic [31:0] a, input int w, output int busy_cycles, output int lat);
        wait_cfg = w;
        @(negedge clk);
        pc = a;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        busy_cycles = 0;
        lat = 1;
        while (!instr_valid && lat < 60) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            lat++;
        end
        if (!instr_valid) begin
            n_vec++; n_err++;
            $display("FAIL fetch_done: got no instr_valid in %0d cycles, want a strobe", lat);
        end
    endtask

    initial begin
        int bc;
        int lat;
        int n;

        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_ir", ir, 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fault", 32'(fault), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait fetch of add $s0,$s1,$s2.
        addr_q.push_back(32'h40);
        push_exp(32'h0232_8020, 6'd0, 5'd17, 5'd18, 5'd16, 5'd0, 6'h20, 16'h8020);
        do_fetch(32'h40, 0, bc, lat);
        check("zw_latency", lat, 2);
        check("zw_busy_cycles", bc, 1);
        check("zw_fault", 32'(fault), 0);

        // Three wait states.
        addr_q.push_back(32'h40);
        push_exp(32'h0232_8020, 6'd0, 5'd17, 5'd18, 5'd16, 5'd0, 6'h20, 16'h8020);
        do_fetch(32'h40, 3, bc, lat);
        check("ws_busy_cycles", bc, 4);
        check("ws_latency", lat, 5);

        // Misaligned pc: no request, sticky fault, IR untouched.
        @(negedge clk);
        pc = 32'h42;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        check("mis_fault", 32'(fault), 1);
        check("mis_busy", 32'(busy), 0);
        check("mis_mem_req", 32'(mem_req), 0);
        repeat (3) @(negedge clk);
        check("mis_fault_sticky", 32'(fault), 1);
        check("mis_ir_kept", ir, 32'h0232_8020);

        // Aligned fetch clears the fault.
        addr_q.push_back(32'h44);
        push_exp(32'h2108_FFFC, 6'h08, 5'd8, 5'd8, 5'd31, 5'd31, 6'h3C, 16'hFFFC);
        do_fetch(32'h44, 1, bc, lat);
        check("clr_fault", 32'(fault), 0);
        check("clr_busy_cycles", bc, 2);

        // fetch_start held through the busy period, then honoured in the strobe cycle.
        addr_q.push_back(32'h48);
        push_exp(32'h0009_4880, 6'd0, 5'd0, 5'd9, 5'd9, 5'd2, 6'h00, 16'h4880);
        addr_q.push_back(32'h4C);
        push_exp(32'hAC0A_0008, 6'h2B, 5'd0, 5'd10, 5'd0, 5'd0, 6'h08, 16'h0008);
        wait_cfg = 2;
        @(negedge clk);
        pc = 32'h48;
        fetch_start = 1'b1;
        @(negedge clk);
        pc = 32'h4C;
        bc = 0;
        n = 0;
        while (!instr_valid && n < 40) begin
            if (busy) bc++;
            @(negedge clk);
            n++;
        end
        check("b2b_first_busy", bc, 3);
        check("b2b_first_valid", 32'(instr_valid), 1);
        @(negedge clk);
        fetch_start = 1'b0;
        check("b2b_req_next", 32'(mem_req), 1);
        check("b2b_addr_next", mem_addr, 32'h4C);
        n = 0;
        while (!instr_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_second_valid", 32'(instr_valid), 1);
        @(negedge clk);

        // Reset in WAIT: request drops at once, late mem_ready ignored.
        addr_q.push_back(32'h40);
        mem_stall = 1'b1;
        @(negedge clk);
        pc = 32'h40;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(mem_req), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ir", ir, 0);
        force_ready = 1'b1;
        mem_stall = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_ir", ir, 0);
        check("post_rst_mem_req", 32'(mem_req), 0);
        force_ready = 1'b0;
        @(negedge clk);

`ifdef FETCH_TIMEOUT_EN
        // Memory never answers: abort after 16 request cycles.
        addr_q.push_back(32'h40);
        mem_stall = 1'b1;
        @(negedge clk);
        pc = 32'h40;
        fetch_start = 1'b1;
        @(negedge clk);
        fetch_start = 1'b0;
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("to_req_cycles", n, 16);
        check("to_fault", 32'(fault), 1);
        check("to_ir_kept", ir, 0);
        mem_stall = 1'b0;

        // Response on the terminal-count cycle completes normally.
        addr_q.push_back(32'h40);
        push_exp(32'h0232_8020, 6'd0, 5'd17, 5'd18, 5'd16, 5'd0, 6'h20, 16'h8020);
        do_fetch(32'h40, 15, bc, lat);
        check("to_edge_busy", bc, 16);
        check("to_edge_fault", 32'(fault), 0);
`else
        // Without the watchdog a slow memory is simply waited for.
        addr_q.push_back(32'h40);
        push_exp(32'h0232_8020, 6'd0, 5'd17, 5'd18, 5'd16, 5'd0, 6'h20, 16'h8020);
        do_fetch(32'h40, 40, bc, lat);
        check("long_wait_busy", bc, 41);
        check("long_wait_fault", 32'(fault), 0);
`endif

        repeat (3) @(negedge clk);
        check("addr_q_drained", addr_q.size(), 0);
        check("exp_q_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
